// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register for the 5-stage core.
// Carries a payload plus valid bit and applies the shared stall vector (load,
// hold or bubble) and an exception flush. It also keeps saturating bubble, hold
// and flush counters for performance debug.
module pipe_stage_reg #(
  parameter int unsigned          DATA_W  = 128,
  parameter int unsigned          STALL_W = 6,
  parameter int unsigned          STAGE   = 2,
  parameter logic [DATA_W-1:0]    NOP_VAL = '0,
  parameter int unsigned          CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               cnt_clr,
  input  logic               d_valid,
  input  logic [DATA_W-1:0]  d_data,
  output logic               q_valid,
  output logic [DATA_W-1:0]  q_data,
  output logic [1:0]         q_state,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   hold_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  // The register looks at its own stall bit and the one downstream of it, so the
  // downstream index must exist inside the stall vector.
  if (STAGE > STALL_W - 2) begin : g_bad_stage
    $error("pipe_stage_reg: STAGE must be in 0..STALL_W-2");
  end

  // Action taken on an edge; the encoding is the visible q_state value.
  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_HOLD   = 2'd1,
    ACT_BUBBLE = 2'd2,
    ACT_FLUSH  = 2'd3
  } action_e;

  logic up;
  logic dn;

  // Only two bits of the stall vector matter here; the rest belong to other stages.
  logic unused_stall;

  logic              valid_d,  valid_q;
  logic [DATA_W-1:0] data_d,   data_q;
  action_e           state_d,  state_q;
  logic [CNT_W-1:0]  bubble_cnt_d, bubble_cnt_q;
  logic [CNT_W-1:0]  hold_cnt_d,   hold_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_d,  flush_cnt_q;

  assign up           = stall[STAGE];
  assign dn           = stall[STAGE+1];
  assign unused_stall = ^stall;

  // Saturating increment: a counter parked at all-ones stays there.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (cnt == {CNT_W{1'b1}}) begin
      return cnt;
    end
    return cnt + CNT_W'(1);
  endfunction

  // Choose this cycle's action by priority: flush, bubble, hold, then load.
  // A load ignores dn because ctrl only ever produces monotone stall vectors.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    state_d = state_q;
    if (flush) begin
      valid_d = 1'b0;
      data_d  = NOP_VAL;
      state_d = ACT_FLUSH;
    end else if (up && !dn) begin
      valid_d = 1'b0;
      data_d  = NOP_VAL;
      state_d = ACT_BUBBLE;
    end else if (up && dn) begin
      state_d = ACT_HOLD;
    end else begin
      valid_d = d_valid;
      data_d  = d_data;
      state_d = ACT_LOAD;
    end
  end

  // Counters follow the chosen action; a clear on the same edge beats any increment.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (cnt_clr) begin
      bubble_cnt_d = '0;
      hold_cnt_d   = '0;
      flush_cnt_d  = '0;
    end else begin
      unique case (state_d)
        ACT_BUBBLE: bubble_cnt_d = sat_inc(bubble_cnt_q);
        ACT_HOLD:   hold_cnt_d   = sat_inc(hold_cnt_q);
        ACT_FLUSH:  flush_cnt_d  = sat_inc(flush_cnt_q);
        default:    ;
      endcase
    end
  end

  // Entry and action record; reset leaves a NOP in the slot and reports LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= NOP_VAL;
      state_q <= ACT_LOAD;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      state_q <= state_d;
    end
  end

  // Performance counters, cleared by reset as well as by cnt_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= '0;
      hold_cnt_q   <= '0;
      flush_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign q_valid    = valid_q;
  assign q_data     = data_q;
  assign q_state    = state_q;
  assign bubble_cnt = bubble_cnt_q;
  assign hold_cnt   = hold_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule
